// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared constants and types for the RGB LED intensity path.
//   PWM_BITS      default intensity / PWM counter width (period = 2^PWM_BITS)
//   NUM_CH        number of colour channels (index 0 = red, 1 = green, 2 = blue)
//   fade_state_e  fade controller state encoding (ST_IDLE, ST_FADE)
// ----------------------------------------------------------------------------
package led_pkg;

    localparam int PWM_BITS = 8;
    localparam int NUM_CH   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FADE = 1'b1
    } fade_state_e;

endpackage : led_pkg

// File: rtl/pwm_channel.sv
// ----------------------------------------------------------------------------
// pwm_channel
// One PWM output driven from the shared period counter.
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   cnt         in   shared free-running PWM counter
//   period_end  in   high while cnt is at its last value of the period
//   level       in   requested intensity, sampled only at the period boundary
//   out         out  registered PWM bit, high for 'duty' cycles per period
// ----------------------------------------------------------------------------
module pwm_channel #(
    parameter int PWM_BITS = led_pkg::PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                period_end,
    input  logic [PWM_BITS-1:0] level,
    output logic                out
);

    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic                out_q;
    logic                out_d;

    // The shadow copy only follows 'level' at the period boundary, so a
    // fade step never produces a truncated or doubled pulse mid-period.
    // The compare uses the old duty on the boundary edge, which still
    // belongs to the finishing period.
    always_comb begin
        duty_d = period_end ? level : duty_q;
        out_d  = (duty_q > cnt);
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
            out_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

endmodule : pwm_channel

// File: rtl/rgb_fade_pwm.sv
// ----------------------------------------------------------------------------
// rgb_fade_pwm
// Per-channel intensity engine: accepts a target colour over valid/ready,
// walks each channel's current intensity one step per 'tick' toward it, and
// drives PWM outputs for the downstream LED driver.
//   clk                  in   system clock
//   rst                  in   synchronous, active-high reset
//   tick                 in   single-cycle fade-step strobe
//   tgt_r/tgt_g/tgt_b    in   target intensities, sampled on accept
//   tgt_valid            in   target offered
//   tgt_ready            out  block can accept a target (idle, not in reset)
//   busy                 out  fade in progress
//   r/g/b                out  PWM outputs
// ----------------------------------------------------------------------------
module rgb_fade_pwm #(
    parameter int PWM_BITS = led_pkg::PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] tgt_r,
    input  logic [PWM_BITS-1:0] tgt_g,
    input  logic [PWM_BITS-1:0] tgt_b,
    input  logic                tgt_valid,
    output logic                tgt_ready,
    output logic                busy,
    output logic                r,
    output logic                g,
    output logic                b
);

    import led_pkg::*;

    typedef logic [PWM_BITS-1:0] level_t;
    typedef level_t [NUM_CH-1:0] colour_t;

    localparam level_t LEVEL_ONE = level_t'(1);

    fade_state_e state_q;
    fade_state_e state_d;

    colour_t cur_q;
    colour_t cur_d;
    colour_t tgt_q;
    colour_t tgt_d;
    colour_t tgt_in;
    colour_t stepped;

    level_t  cnt_q;
    level_t  cnt_d;
    logic    period_end;

    logic    accept;
    logic    tgt_is_cur;
    logic    step_done;

    logic [NUM_CH-1:0] pwm_out;

    assign tgt_in = {tgt_b, tgt_g, tgt_r};

    // ------------------------------------------------------------------
    // Per-channel step toward the registered target. Moving only toward
    // tgt_q means cur can never run past 0 or full scale.
    // ------------------------------------------------------------------
    always_comb begin
        stepped = cur_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (cur_q[ch] < tgt_q[ch]) begin
                stepped[ch] = cur_q[ch] + LEVEL_ONE;
            end else if (cur_q[ch] > tgt_q[ch]) begin
                stepped[ch] = cur_q[ch] - LEVEL_ONE;
            end
        end
    end

    assign accept     = tgt_valid && tgt_ready;
    assign tgt_is_cur = (tgt_in == cur_q);
    assign step_done  = (stepped == tgt_q);

    // ------------------------------------------------------------------
    // Fade FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Fade FSM: next state
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && !tgt_is_cur) begin
                    state_d = ST_FADE;
                end
            end
            ST_FADE: begin
                // Leave on the same edge that lands the last step.
                if (tick && step_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Fade FSM: outputs
    // ------------------------------------------------------------------
    // tgt_ready looks only at the state and rst, never at tgt_valid, so the
    // upstream handshake cannot form a combinational loop through here.
    always_comb begin
        tgt_ready = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: tgt_ready = !rst;
            ST_FADE: busy      = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: target capture, intensity stepping, shared PWM counter
    // ------------------------------------------------------------------
    always_comb begin
        tgt_d = accept ? tgt_in : tgt_q;
        // Stepping is gated by the registered state, so a tick arriving in
        // the accept cycle sees IDLE and is ignored.
        cur_d = ((state_q == ST_FADE) && tick) ? stepped : cur_q;
        cnt_d = cnt_q + LEVEL_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= '0;
            tgt_q <= '0;
            cnt_q <= '0;
        end else begin
            cur_q <= cur_d;
            tgt_q <= tgt_d;
            cnt_q <= cnt_d;
        end
    end

    assign period_end = (cnt_q == '1);

    // ------------------------------------------------------------------
    // PWM outputs, one per colour channel
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_pwm (
            .clk        (clk),
            .rst        (rst),
            .cnt        (cnt_q),
            .period_end (period_end),
            .level      (cur_q[ch]),
            .out        (pwm_out[ch])
        );
    end

    assign r = pwm_out[0];
    assign g = pwm_out[1];
    assign b = pwm_out[2];

endmodule : rgb_fade_pwm

// File: tb/tb_rgb_fade_pwm.sv
// ----------------------------------------------------------------------------
// tb_rgb_fade_pwm
// Self-checking bench for rgb_fade_pwm. Expected fade lengths come from the
// largest per-channel distance to the target, and expected PWM waveforms from
// the settled intensity: D high cycles at the start of each 256-cycle period.
// ----------------------------------------------------------------------------
module tb_rgb_fade_pwm;

    localparam int PERIOD = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [7:0] tgt_r;
    logic [7:0] tgt_g;
    logic [7:0] tgt_b;
    logic       tgt_valid;
    logic       tgt_ready;
    logic       busy;
    logic       r;
    logic       g;
    logic       b;

    rgb_fade_pwm #(
        .PWM_BITS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .tgt_r     (tgt_r),
        .tgt_g     (tgt_g),
        .tgt_b     (tgt_b),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .busy      (busy),
        .r         (r),
        .g         (g),
        .b         (b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Settled intensity of each channel, as the bench expects it.
    int m_cur[3];
    // PWM counter value that the next edge will see, and the value the
    // most recent edge saw (the output sampled now reflects the latter).
    int m_cnt    = 0;
    int last_cnt = 0;

    int meas_hi[3];
    bit meas_ok[3];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    // One clock edge; samples are taken 1 time unit after it.
    task automatic clk_step();
        @(posedge clk);
        last_cnt = m_cnt;
        m_cnt    = rst ? 0 : (m_cnt + 1) % PERIOD;
        #1;
    endtask

    function automatic int fade_len(input int t0, input int t1, input int t2);
        int d[3];
        int mx;
        d[0] = (t0 > m_cur[0]) ? t0 - m_cur[0] : m_cur[0] - t0;
        d[1] = (t1 > m_cur[1]) ? t1 - m_cur[1] : m_cur[1] - t1;
        d[2] = (t2 > m_cur[2]) ? t2 - m_cur[2] : m_cur[2] - t2;
        mx = d[0];
        if (d[1] > mx) mx = d[1];
        if (d[2] > mx) mx = d[2];
        return mx;
    endfunction

    // Offer a target for one cycle, then strobe tick with gaps in
    // [min_gap, max_gap] until busy drops (bounded at 300 ticks).
    task automatic run_fade(input int t0, input int t1, input int t2,
                            input int min_gap, input int max_gap,
                            output logic busy_after, output logic ready_after,
                            output int nticks);
        int gap;
        tgt_r     = 8'(t0);
        tgt_g     = 8'(t1);
        tgt_b     = 8'(t2);
        tgt_valid = 1'b1;
        tick      = 1'b0;
        clk_step();
        tgt_valid   = 1'b0;
        busy_after  = busy;
        ready_after = tgt_ready;
        nticks      = 0;
        while (busy === 1'b1 && nticks < 300) begin
            gap = $urandom_range(max_gap, min_gap);
            repeat (gap - 1) clk_step();
            tick = 1'b1;
            clk_step();
            tick = 1'b0;
            nticks++;
        end
    endtask

    // Capture exactly one PWM period, aligned so sample k reflects cnt = k.
    task automatic measure();
        int   guard;
        logic [PERIOD-1:0] bits [3];
        tick = 1'b0;
        clk_step();
        guard = 0;
        while (last_cnt != PERIOD - 1 && guard < 600) begin
            clk_step();
            guard++;
        end
        checks++;
        if (guard >= 600) begin
            errors++;
            $display("FAIL measure_align: got no period boundary within %0d cycles, required one", guard);
        end
        for (int k = 0; k < PERIOD; k++) begin
            clk_step();
            bits[0][k] = r;
            bits[1][k] = g;
            bits[2][k] = b;
        end
        for (int c = 0; c < 3; c++) begin
            meas_hi[c] = 0;
            for (int k = 0; k < PERIOD; k++) if (bits[c][k] === 1'b1) meas_hi[c]++;
            meas_ok[c] = 1'b1;
            for (int k = 0; k < PERIOD; k++) begin
                if (bits[c][k] !== ((k < meas_hi[c]) ? 1'b1 : 1'b0)) meas_ok[c] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; tgt_valid = 1'b0;
        tgt_r = '0; tgt_g = '0; tgt_b = '0;
        clk_step();
        checks++;
        if ({r, g, b, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got rgb_busy=%b, required 0000", {r, g, b, busy});
        end
        checks++;
        if (tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %b, required 0", tgt_ready);
        end
        clk_step();
        clk_step();
        rst = 1'b0;
        m_cur = '{0, 0, 0};
        clk_step();
        checks++;
        if (tgt_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b busy=%b, required ready=1 busy=0", tgt_ready, busy);
        end
        measure();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (meas_hi[c] != 0) begin
                errors++;
                $display("FAIL reset_duty ch%0d: got %0d high cycles, required 0", c, meas_hi[c]);
            end
        end
    endtask

    task automatic check_duties(input string name);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (meas_hi[c] != m_cur[c] || !meas_ok[c]) begin
                errors++;
                $display("FAIL %s ch%0d: got %0d high cycles (contiguous=%0b), required %0d contiguous from cnt 0",
                         name, c, meas_hi[c], meas_ok[c], m_cur[c]);
            end
        end
    endtask

    task automatic test_fade_up();
        logic ba, ra;
        int   n;
        int   exp_n;
        exp_n = fade_len(255, 0, 128);
        run_fade(255, 0, 128, 10, 10, ba, ra, n);
        checks++;
        if (ba !== 1'b1 || ra !== 1'b0) begin
            errors++;
            $display("FAIL fade_up_accept: got busy=%b ready=%b, required busy=1 ready=0", ba, ra);
        end
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL fade_up_ticks: got busy for %0d ticks, required %0d", n, exp_n);
        end
        m_cur = '{255, 0, 128};
        measure();
        check_duties("fade_up_duty");
    endtask

    task automatic test_pwm_duty();
        logic ba, ra;
        int   n;
        int   exp_n;
        exp_n = fade_len(64, 0, 0);
        run_fade(64, 0, 0, 1, 3, ba, ra, n);
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL pwm_duty_ticks: got %0d ticks, required %0d", n, exp_n);
        end
        m_cur = '{64, 0, 0};
        for (int p = 0; p < 2; p++) begin
            measure();
            check_duties("pwm_duty");
        end
    endtask

    task automatic test_noop();
        logic ba, ra;
        int   n;
        int   exp_n;
        exp_n = fade_len(10, 10, 10);
        run_fade(10, 10, 10, 1, 2, ba, ra, n);
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL noop_setup_ticks: got %0d ticks, required %0d", n, exp_n);
        end
        m_cur = '{10, 10, 10};
        tgt_r = 8'd10; tgt_g = 8'd10; tgt_b = 8'd10;
        tgt_valid = 1'b1;
        clk_step();
        tgt_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || tgt_ready !== 1'b1) begin
            errors++;
            $display("FAIL noop_accept: got busy=%b ready=%b, required busy=0 ready=1", busy, tgt_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; clk_step(); tick = 1'b0; clk_step();
        end
        checks++;
        if (busy !== 1'b0 || tgt_ready !== 1'b1) begin
            errors++;
            $display("FAIL noop_after_ticks: got busy=%b ready=%b, required busy=0 ready=1", busy, tgt_ready);
        end
        measure();
        check_duties("noop_duty");
    endtask

    task automatic test_handshake();
        int n;
        int exp_up;
        int exp_down;
        int ready_bad;
        exp_up = fade_len(200, 30, 10);
        tgt_r = 8'd200; tgt_g = 8'd30; tgt_b = 8'd10;
        tgt_valid = 1'b1;
        tick = 1'b0;
        clk_step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hs_first_accept: got busy=%b, required 1", busy);
        end
        // Second offer held for the whole fade.
        tgt_r = 8'd0; tgt_g = 8'd0; tgt_b = 8'd0;
        n = 0;
        ready_bad = 0;
        while (busy === 1'b1 && n < 300) begin
            repeat (2) begin
                clk_step();
                if (busy === 1'b1 && tgt_ready !== 1'b0) ready_bad++;
            end
            tick = 1'b1;
            clk_step();
            tick = 1'b0;
            n++;
            if (busy === 1'b1 && tgt_ready !== 1'b0) ready_bad++;
        end
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL hs_ready_during_fade: got ready=1 in %0d busy cycles, required 0", ready_bad);
        end
        checks++;
        if (n != exp_up) begin
            errors++;
            $display("FAIL hs_fade_up_ticks: got %0d ticks, required %0d", n, exp_up);
        end
        m_cur = '{200, 30, 10};
        checks++;
        if (tgt_ready !== 1'b1) begin
            errors++;
            $display("FAIL hs_idle_ready: got %b, required 1", tgt_ready);
        end
        // Pending offer is accepted now; the coincident tick must not step.
        exp_down = fade_len(0, 0, 0);
        tick = 1'b1;
        clk_step();
        tick = 1'b0;
        tgt_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hs_second_accept: got busy=%b, required 1", busy);
        end
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            clk_step();
            tick = 1'b1;
            clk_step();
            tick = 1'b0;
            n++;
        end
        checks++;
        if (n != exp_down) begin
            errors++;
            $display("FAIL hs_fade_down_ticks: got %0d ticks, required %0d", n, exp_down);
        end
        m_cur = '{0, 0, 0};
        measure();
        check_duties("hs_duty");
    endtask

    task automatic test_random();
        logic ba, ra;
        int   n;
        int   t[3];
        int   exp_n;
        for (int it = 0; it < 4; it++) begin
            for (int c = 0; c < 3; c++) t[c] = $urandom_range(255, 0);
            exp_n = fade_len(t[0], t[1], t[2]);
            run_fade(t[0], t[1], t[2], 1, 4, ba, ra, n);
            checks++;
            if (ba !== ((exp_n > 0) ? 1'b1 : 1'b0) || n != exp_n) begin
                errors++;
                $display("FAIL random_fade it%0d: got busy_after=%b ticks=%0d, required busy_after=%0b ticks=%0d",
                         it, ba, n, (exp_n > 0), exp_n);
            end
            m_cur = '{t[0], t[1], t[2]};
            measure();
            check_duties("random_duty");
        end
    endtask

    task automatic test_reset_mid_fade();
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        m_cur = '{0, 0, 0};
        tgt_r = 8'd200; tgt_g = 8'd150; tgt_b = 8'd120;
        tgt_valid = 1'b1;
        clk_step();
        tgt_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick = 1'b1; clk_step(); tick = 1'b0; clk_step();
        end
        // Let the partially faded level (100,100,100) reach the PWM outputs.
        repeat (300) clk_step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_fade_busy: got %b, required 1", busy);
        end
        rst = 1'b1;
        clk_step();
        checks++;
        if ({r, g, b, busy} !== 4'b0000 || tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rgb_busy=%b ready=%b, required 0000 ready=0",
                     {r, g, b, busy}, tgt_ready);
        end
        clk_step();
        clk_step();
        rst = 1'b0;
        m_cur = '{0, 0, 0};
        clk_step();
        checks++;
        if (tgt_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_release: got ready=%b, required 1", tgt_ready);
        end
        for (int i = 0; i < 20; i++) begin
            tick = 1'b1; clk_step(); tick = 1'b0; clk_step();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ticks_busy: got %b, required 0", busy);
        end
        measure();
        check_duties("mid_reset_duty");
    endtask

    initial begin
        test_reset();
        test_fade_up();
        test_pwm_duty();
        test_noop();
        test_handshake();
        test_random();
        test_reset_mid_fade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rgb_fade_pwm

// File: doc/rgb_fade_pwm.md
# rgb_fade_pwm

Per-channel intensity engine for the RGB LED. It accepts a target colour (8-bit R/G/B) over a valid/ready handshake and ramps each channel's current intensity toward the target by one step per `tick` strobe. It then drives pulse-width-modulated `r`/`g`/`b` bits. It sits directly upstream of `rgb_led`, replacing the on/off `r`/`g`/`b` of the blink pattern with dimmable outputs. `tick` is driven from `tick_100ms` or any other single-cycle strobe.

## Interface
- `PWM_BITS`, 8: intensity and PWM counter width. Period = 2^PWM_BITS clocks.
- `clk`  in  1  system clock (`CLK` at top).
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  single-cycle fade-step strobe.
- `tgt_r`, `tgt_g`, `tgt_b`  in  PWM_BITS each  target intensities, sampled on accept.
- `tgt_valid`  in  1  target offered.
- `tgt_ready`  out  1  block can accept a target.
- `busy`  out  1  fade in progress.
- `r`, `g`, `b`  out  1 each  PWM outputs to `rgb_led`.

## Operation
- Reset: one clock, synchronous, active-high; `rst` sampled on the rising edge of `clk`.
- State machine, two states:
  - IDLE: `tgt_ready`=1.
  - FADE: `tgt_ready`=0, `busy`=1.
- Accept = `tgt_valid && tgt_ready` on a rising edge. Registers the target into `tgt_q`.
  - If `tgt_q` equals `cur` on all channels, stay in IDLE.
  - Otherwise go to FADE.
- In FADE, on each `tick`, each channel independently steps:
  - `cur` < `tgt_q`: `cur`+1.
  - `cur` > `tgt_q`: `cur`-1.
  - Equal: hold.
- Return to IDLE in the same edge where the post-step `cur` equals `tgt_q` on all channels.
- A `tick` in the accept cycle is ignored; stepping begins at the first `tick` after acceptance.
- `tgt_valid` while in FADE is ignored. The offer stays pending and is accepted in the first IDLE cycle if still asserted. Targets are never queued.
- Arithmetic: `cur` saturates by construction (moves only toward `tgt_q`); no wrap. Unsigned comparisons.
- PWM counter `cnt` (PWM_BITS) is free-running, increments every clock, and wraps from 2^PWM_BITS-1 to 0.
- Per channel, `duty` shadow register loads `cur` when `cnt` = 2^PWM_BITS-1, so duty changes only at period boundaries.
- Output is registered: `out` <= (`duty` > `cnt`).
  - Duty 0: constantly low.
  - Duty 255: high 255 of 256 cycles.
  - Duty D: high for D consecutive cycles per period.
- Reset: `cur`, `tgt_q`, `duty` and `cnt` all reset to 0; state resets to IDLE.
- `r`, `g`, `b` and `busy` reset to 0.
- `tgt_ready` is 0 while `rst` is high and 1 from the first cycle after release.
- Reset mid-fade aborts immediately; no partial state survives.

## Timing
- Accept to `busy`=1: registered, visible the cycle after the accept edge.
- Fade duration: max over channels of |`tgt` - `cur`| ticks. `busy` falls the cycle after the final tick edge.
- PWM output latency: `r` reflects `cnt`=k one clock later. The pulse for duty D spans output cycles for `cnt` values 0..D-1, delayed by 1 clock.
- Duty update latency: a `cur` change becomes visible in PWM from the next period start, at most 2^PWM_BITS+1 clocks later.
- No combinational path from inputs to outputs except `tgt_ready`, which derives from the state register and `rst` only (not from `tgt_valid`).

## Structure
- Shared package `led_pkg`:
  - `PWM_BITS` default constant.
  - Fade state encoding: `ST_IDLE`, `ST_FADE`.
- Sub-module `pwm_channel`, instanced three times:
  - Inputs: `clk`, `rst`, `cnt`, `period_end`, `level`.
  - Holds the duty shadow register and the registered compare.
  - Outputs: `out`.
- The shared counter, fade FSM and per-channel step logic live in `rgb_fade_pwm`.

## Test plan
- Reset: `rst` high for 3 clocks mid-operation -> next cycle `r`/`g`/`b`=0 and `busy`=0; `tgt_ready`=1 one cycle after release; `cur`=0.
- Fade up: accept (255,0,128), pulse `tick` every 10 clocks -> `b` reaches 128 after 128 ticks and holds; `r` reaches 255 after 255 ticks; `busy` falls the cycle after tick 255.
- PWM duty: settle `r` at 64 -> `r` high exactly 64 cycles in each 256-cycle period, contiguous, starting one clock after `cnt`=0; `g`=0 never high.
- No-op target: with `cur`=(10,10,10), accept (10,10,10) -> `busy` stays 0 and `tgt_ready` stays 1.
- Handshake: hold `tgt_valid` with new target (0,0,0) during a fade -> `tgt_ready`=0 throughout the fade; target accepted on the first IDLE cycle; fade down follows; a `tick` coincident with the accept does not step.
- Reset mid-fade at `cur`=(100,…) -> all state 0 next cycle; subsequent ticks without a new target change nothing.
